fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/cpu_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 57 +++++
 rtl/fetch_unit.sv | 112 +++++++++++
 tb/tb_fetch_unit.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU front-end types: fetch FSM states, machine word and queue entry.
package cpu_pkg;

    typedef logic [31:0] word_t;

    localparam word_t PC_INC = 32'd4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_REQ  = 2'd1,
        ST_DROP = 2'd2
    } fetch_state_t;

    typedef struct packed {
        word_t instr;
        word_t pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Circular instruction queue; flush empties it, head is presented combinationally.
module fetch_fifo
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic                         flush,
    input  fetch_entry_t                 din,
    output fetch_entry_t                 dout,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [PW-1:0] PTR_LAST = PW'(DEPTH - 1);

    fetch_entry_t  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;

    function automatic logic [PW-1:0] wrap_inc(input logic [PW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + PW'(1);
    endfunction

    always_ff @(posedge clk) begin
        if (rst_n && !flush && push) begin
            mem[wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wrap_inc(wr_ptr);
            end
            if (pop) begin
                rd_ptr <= wrap_inc(rd_ptr);
            end
            if (push && !pop) begin
                count <= count + CW'(1);
            end else if (pop && !push) begin
                count <= count - CW'(1);
            end
        end
    end

    assign dout = mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: single-outstanding memory requester feeding a small queue,
// with branch redirect that flushes the queue and discards an in-flight response.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter word_t       RESET_PC = 32'h0000_0000,
    parameter int unsigned DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instruction,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEPTH - 1);

    fetch_state_t  state;
    fetch_state_t  state_nx;
    word_t         pc;
    word_t         pc_nx;
    word_t         req_addr;
    word_t         req_addr_nx;
    word_t         fetch_addr;
    logic [CW-1:0] count;
    logic          active;
    logic          push;
    logic          pop;
    logic          flush;
    fetch_entry_t  head;
    logic          redirect_pc_unused;

    assign redirect_pc_unused = ^redirect_pc[1:0];

    // req_addr keeps the in-flight address stable in DROP while pc already holds the target.
    always_comb begin
        state_nx    = state;
        pc_nx       = pc;
        req_addr_nx = req_addr;
        push        = 1'b0;
        flush       = 1'b0;
        active      = 1'b0;
        fetch_addr  = pc;
        case (state)
            ST_IDLE: active = !redirect && (count < CNT_FULL);
            default: begin
                active     = 1'b1;
                fetch_addr = req_addr;
            end
        endcase

        if (redirect) begin
            flush    = 1'b1;
            pc_nx    = {redirect_pc[31:2], 2'b00};
            state_nx = (state != ST_IDLE && !imem_ack) ? ST_DROP : ST_IDLE;
        end else if (active && imem_ack) begin
            if (state == ST_DROP) begin
                state_nx = ST_IDLE;
            end else begin
                push        = 1'b1;
                pc_nx       = pc + PC_INC;
                req_addr_nx = pc + PC_INC;
                state_nx    = (count < CNT_LAST) ? ST_REQ : ST_IDLE;
            end
        end else if (active) begin
            state_nx    = (state == ST_IDLE) ? ST_REQ : state;
            req_addr_nx = fetch_addr;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            pc       <= RESET_PC;
            req_addr <= RESET_PC;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            req_addr <= req_addr_nx;
        end
    end

    assign imem_req    = rst_n && active;
    assign imem_addr   = rst_n ? fetch_addr : RESET_PC;
    assign instr_valid = rst_n && (count != '0);
    assign pop         = instr_valid && instr_ready && !redirect;
    assign instruction = head.instr;
    assign instr_pc    = head.pc;

    fetch_fifo #(
        .DEPTH(DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .flush (flush),
        .din   ('{instr: imem_rdata, pc: pc}),
        .dout  (head),
        .count (count)
    );

endmodule

// File: tb/tb_fetch_unit.sv
// Fetch unit bench: queue-based behavioural model compared every cycle, plus directed scenarios.
module tb_fetch_unit;
    import cpu_pkg::*;

    localparam int unsigned DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instruction;
    logic [31:0] instr_pc;
    logic        redirect;
    logic [31:0] redirect_pc;

    always #5 clk = ~clk;

    fetch_unit #(
        .RESET_PC(RESET_PC),
        .DEPTH   (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instruction (instruction),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_pc = RESET_PC;
    logic [31:0] m_oaddr = RESET_PC;
    bit          m_out = 1'b0;
    bit          m_drop = 1'b0;
    int          m_pushes = 0;

    logic        e_req, e_valid;
    logic [31:0] e_addr, e_instr, e_pc;

    int checks = 0;
    int failures = 0;
    bit cmp_en = 1'b0;

    function automatic void cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] rdf(input logic [31:0] a);
        return {~a[15:0], a[15:0]} ^ 32'h5A5A_0000;
    endfunction

    task automatic drive(input logic rst, input logic ack, input logic [31:0] rd,
                         input logic rdy, input logic redir, input logic [31:0] rpc);
        rst_n       = rst;
        imem_ack    = ack;
        imem_rdata  = rd;
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        if (!rst) begin
            e_req   = 1'b0;
            e_addr  = RESET_PC;
            e_valid = 1'b0;
        end else begin
            e_req   = m_out || (!redir && q.size() < int'(DEPTH));
            e_addr  = m_out ? m_oaddr : m_pc;
            e_valid = (q.size() != 0);
        end
        if (q.size() != 0) begin
            e_instr = q[0].instr;
            e_pc    = q[0].pc;
        end
    endtask

    task automatic model_update();
        int n0;
        if (!rst_n) begin
            q.delete();
            m_pc   = RESET_PC;
            m_out  = 1'b0;
            m_drop = 1'b0;
        end else if (redirect) begin
            q.delete();
            if (m_out && !imem_ack) begin
                m_drop = 1'b1;
            end else begin
                m_out  = 1'b0;
                m_drop = 1'b0;
            end
            m_pc = {redirect_pc[31:2], 2'b00};
        end else begin
            n0 = q.size();
            if (n0 != 0 && instr_ready) q.delete(0);
            if (e_req && imem_ack) begin
                if (m_drop) begin
                    m_out  = 1'b0;
                    m_drop = 1'b0;
                end else begin
                    q.push_back('{instr: imem_rdata, pc: m_pc});
                    m_pushes++;
                    m_pc    = m_pc + 32'd4;
                    m_oaddr = m_pc;
                    m_out   = (n0 + 1 < int'(DEPTH));
                end
            end else if (e_req) begin
                m_out   = 1'b1;
                m_oaddr = e_addr;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic do_reset();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
    endtask

    always @(negedge clk) begin
        if (cmp_en) begin
            cmp("imem_req", 32'(imem_req), 32'(e_req));
            cmp("imem_addr", imem_addr, e_addr);
            cmp("instr_valid", 32'(instr_valid), 32'(e_valid));
            if (e_valid) begin
                cmp("instruction", instruction, e_instr);
                cmp("instr_pc", instr_pc, e_pc);
            end
        end
    end

    initial begin
        logic [31:0] pcs [3];
        logic [31:0] faddr [3];
        int          got;
        logic        r, redir, rdy, ack, issue;
        logic [31:0] rpc;

        for (int i = 0; i < 3; i++) begin
            pcs[i]   = 32'hDEAD_BEEF;
            faddr[i] = 32'hDEAD_BEEF;
        end

        do_reset();
        cmp_en = 1'b1;
        drive(1'b0, 1'b0, '0, 1'b0, 1'b0, '0);
        cmp("rst_req", 32'(e_req), 32'd0);
        cmp("rst_addr", e_addr, RESET_PC);
        tick();

        // Sequential fetch with 1-cycle ack latency, decoder always ready
        got = 0;
        for (int c = 0; c < 16 && got < 3; c++) begin
            drive(1'b1, m_out, rdf(m_out ? m_oaddr : m_pc), 1'b1, 1'b0, '0);
            if (c == 0) begin
                cmp("s1_first_req", 32'(e_req), 32'd1);
                cmp("s1_first_addr", e_addr, 32'h0);
            end
            if (e_valid) begin
                pcs[got] = e_pc;
                cmp("s1_instr", e_instr, rdf(e_pc));
                got++;
            end
            tick();
        end
        cmp("s1_pc0", pcs[0], 32'h0);
        cmp("s1_pc1", pcs[1], 32'h4);
        cmp("s1_pc2", pcs[2], 32'h8);

        // Decoder stalled: queue fills, then one pop releases a new request
        do_reset();
        m_pushes = 0;
        for (int c = 0; c < 8; c++) begin
            drive(1'b1, m_out, rdf(m_out ? m_oaddr : m_pc), 1'b0, 1'b0, '0);
            tick();
        end
        cmp("s2_pushes", 32'(m_pushes), 32'd2);
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        cmp("s2_full_req", 32'(e_req), 32'd0);
        cmp("s2_head_pc", e_pc, 32'h0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cmp("s2_req_after_pop", 32'(e_req), 32'd1);
        cmp("s2_addr_after_pop", e_addr, 32'h8);
        tick();

        // Redirect with a request in flight; the late ack must be dropped
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'h103);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        cmp("s3_drop_addr", e_addr, 32'h0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, 32'hBAD0_BAD0, 1'b1, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b0, '0);
        cmp("s3_valid", 32'(e_valid), 32'd0);
        cmp("s3_addr", e_addr, 32'h100);
        tick();

        // Redirect coinciding with ack and pop
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, rdf(32'h0), 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b1, rdf(32'h4), 1'b1, 1'b1, 32'h200);
        cmp("s4_valid_before", 32'(e_valid), 32'd1);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cmp("s4_valid_after", 32'(e_valid), 32'd0);
        cmp("s4_target", e_addr, 32'h200);
        tick();

        // Address wrap through 2^32
        do_reset();
        drive(1'b1, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FFF8);
        tick();
        got = 0;
        for (int c = 0; c < 8 && got < 3; c++) begin
            drive(1'b1, 1'b1, rdf(m_out ? m_oaddr : m_pc), 1'b1, 1'b0, '0);
            if (e_req) begin
                faddr[got] = e_addr;
                got++;
            end
            tick();
        end
        cmp("s5_a0", faddr[0], 32'hFFFF_FFF8);
        cmp("s5_a1", faddr[1], 32'hFFFF_FFFC);
        cmp("s5_a2", faddr[2], 32'h0000_0000);

        // Reset mid-request with ack during reset
        do_reset();
        m_pushes = 0;
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        tick();
        drive(1'b0, 1'b1, 32'h1111_1111, 1'b0, 1'b0, '0);
        tick();
        drive(1'b1, 1'b0, '0, 1'b0, 1'b0, '0);
        cmp("s6_pushes", 32'(m_pushes), 32'd0);
        cmp("s6_req", 32'(e_req), 32'd1);
        cmp("s6_addr", e_addr, RESET_PC);
        tick();

        // Randomized traffic
        for (int c = 0; c < 4000; c++) begin
            r     = ($urandom_range(0, 199) != 0);
            redir = ($urandom_range(0, 15) == 0);
            rpc   = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | 32'($urandom_range(0, 15)))
                                                : 32'($urandom);
            rdy   = 1'($urandom_range(0, 1));
            issue = m_out || (!redir && q.size() < int'(DEPTH));
            if (!r)
                ack = 1'($urandom_range(0, 1));
            else if (m_out)
                ack = ($urandom_range(0, 2) != 0);
            else if (issue)
                ack = ($urandom_range(0, 3) == 0);
            else
                ack = 1'b0;
            drive(r, ack, 32'($urandom), rdy, redir, rpc);
            tick();
        end

        cmp_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
